// File: rtl/interlayer_ifetch_queue_if.sv
// Interface for interlayer_ifetch_queue: bundles the IF-stage fetch handshake
// and the sram-like instruction bus into one port.
// slave  : view taken by the interlayer itself.
// master : view taken by the surrounding environment (IF stage plus bus).
interface interlayer_ifetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IF-stage side
    logic              IF_enable;
    logic [ADDR_W-1:0] IF_mem_addr;
    logic              IF_req_accept;
    logic              IF_skip;
    logic              IF_ready;
    logic [DATA_W-1:0] IF_mem_rdata;
    logic              IF_accept;

    // sram-like instruction bus side
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;

    modport slave (
        input  IF_enable,
        input  IF_mem_addr,
        output IF_req_accept,
        input  IF_skip,
        output IF_ready,
        output IF_mem_rdata,
        input  IF_accept,
        output inst_req,
        output inst_addr,
        input  inst_rdata,
        input  inst_addr_ok,
        input  inst_data_ok
    );

    modport master (
        output IF_enable,
        output IF_mem_addr,
        input  IF_req_accept,
        output IF_skip,
        input  IF_ready,
        input  IF_mem_rdata,
        output IF_accept,
        input  inst_req,
        input  inst_addr,
        output inst_rdata,
        output inst_addr_ok,
        output inst_data_ok
    );
endinterface

// File: rtl/interlayer_ifetch_queue.sv
// interlayer_ifetch_queue
// Sits between the IF stage and the sram-like instruction bus. Up to
// MAX_OUTSTANDING fetches may be in flight; returned words are buffered in a
// FIFO_DEPTH-entry queue so IF can stall without blocking the bus. A request
// is only issued when the queue is guaranteed a slot for its response, so the
// queue can never overflow. IF_skip flushes the queue and remembers how many
// in-flight responses are stale so they are discarded when they arrive.
//
// Optional feature: define INTERLAYER_STATS_EN to add the stat_drop_cnt and
// stat_stall_cnt counters and ports. Without it the block is otherwise
// identical.
//
// FIFO_DEPTH must be a power of two >= 2; MAX_OUTSTANDING must lie in
// 1..FIFO_DEPTH.
module interlayer_ifetch_queue #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst_p,
    interlayer_ifetch_queue_if.slave  bus
`ifdef INTERLAYER_STATS_EN
    ,
    output logic [31:0]               stat_drop_cnt,
    output logic [31:0]               stat_stall_cnt
`endif
);

    // Widths: pointers index the queue, count spans 0..FIFO_DEPTH, the
    // outstanding/drop counters span 0..MAX_OUTSTANDING, and the credit sum
    // (inflight + count) gets one extra bit so it can never wrap.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CNT_W + 1;

    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0] DEPTH_V   = SUM_W'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Architectural state
    logic [OUT_W-1:0]  inflight_q, inflight_d;
    logic [OUT_W-1:0]  drop_q,     drop_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  wptr_q,     wptr_d;
    logic [PTR_W-1:0]  rptr_q,     rptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

    // Per-cycle events
    logic              req;
    logic              handshake;
    logic              dropping;
    logic              push;
    logic              pop;
    logic [SUM_W-1:0]  credit_used;

    // Request credit and per-cycle events. Every accepted request plus every
    // queued word consumes one queue slot, so a request is only made when a
    // slot is still free for its response. A skip cycle never requests, and
    // any response arriving in a skip cycle or while stale responses remain
    // is discarded. A pop during skip is ignored because the flush wins.
    always_comb begin
        credit_used = SUM_W'(inflight_q) + SUM_W'(count_q);
        req         = !rst_p && bus.IF_enable && !bus.IF_skip &&
                      (inflight_q < MAX_OUT_V) && (credit_used < DEPTH_V);
        handshake   = req && bus.inst_addr_ok;
        dropping    = bus.inst_data_ok && (bus.IF_skip || (drop_q != '0));
        push        = bus.inst_data_ok && !dropping;
        pop         = (count_q != '0) && bus.IF_accept && !bus.IF_skip;
    end

    // Outstanding-request and stale-response bookkeeping. On skip every
    // request still in flight becomes stale, except the one whose response
    // is arriving right now, which is dropped directly in this cycle.
    always_comb begin
        inflight_d = inflight_q;
        case ({handshake, bus.inst_data_ok})
            2'b10:   inflight_d = inflight_q + OUT_ONE;
            2'b01:   inflight_d = inflight_q - OUT_ONE;
            default: inflight_d = inflight_q;
        endcase

        drop_d = drop_q;
        if (bus.IF_skip) begin
            if (bus.inst_data_ok && (inflight_q != '0)) begin
                drop_d = inflight_q - OUT_ONE;
            end else begin
                drop_d = inflight_q;
            end
        end else if (dropping) begin
            drop_d = drop_q - OUT_ONE;
        end
    end

    // Response queue: write at wptr, read at rptr, pointers wrap naturally
    // because the depth is a power of two. Push and pop together keep the
    // count unchanged, even when the queue is full. Skip empties the queue.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (push) begin
            mem_d[wptr_q] = bus.inst_rdata;
            wptr_d        = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.IF_skip) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    // State registers with synchronous reset; reset abandons anything in
    // flight since the bus side is reset together with this block.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_q      <= '{default: '0};
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_q      <= mem_d;
        end
    end

    // Outputs: the queue head is registered, so a response shows up on
    // IF_ready/IF_mem_rdata the cycle after inst_data_ok.
    assign bus.inst_req      = req;
    assign bus.inst_addr     = bus.IF_mem_addr;
    assign bus.IF_req_accept = handshake;
    assign bus.IF_ready      = (count_q != '0);
    assign bus.IF_mem_rdata  = mem_q[rptr_q];

`ifdef INTERLAYER_STATS_EN
    logic [31:0] drop_cnt_q,  drop_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Statistics: one count per discarded response, and one per cycle where
    // IF wanted to fetch but was held back (skip cycles excluded). Both wrap.
    always_comb begin
        drop_cnt_d  = drop_cnt_q + (dropping ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q +
                      ((bus.IF_enable && !req && !bus.IF_skip) ? 32'd1 : 32'd0);
    end

    // Statistic registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_drop_cnt  = drop_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_interlayer_ifetch_queue.sv
// Testbench for interlayer_ifetch_queue (FIFO_DEPTH=4, MAX_OUTSTANDING=2).
// The bench plays both the IF stage and an in-order sram-like bus. Expected
// outputs come from a transaction-level model: a queue of outstanding bus
// requests (each tagged stale or live) and a queue of words waiting for IF.
// Define INTERLAYER_STATS_EN to also cover the statistic counters.
module tb_interlayer_ifetch_queue;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int MAXO   = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        stale;
    } pend_t;

    logic clk;
    logic rst_p;
`ifdef INTERLAYER_STATS_EN
    logic [31:0] stat_drop_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    interlayer_ifetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    interlayer_ifetch_queue #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst_p(rst_p),
        .bus(bus_if)
`ifdef INTERLAYER_STATS_EN
        ,
        .stat_drop_cnt(stat_drop_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    pend_t       pend[$];
    logic [31:0] fifo_m[$];
    logic [31:0] word_src[$];
    int          m_drop;
    int          m_stall;

    // Bookkeeping
    int          checks;
    int          failures;
    logic        hs_seen;
    logic        popped_valid;
    logic [31:0] popped_word;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs against the
    // model, then advance the model by what this cycle does.
    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic skip,
                                 input logic acc, input logic aok, input logic want_resp);
        logic  resp;
        logic  exp_req;
        logic  pop_ok;
        pend_t p;
        @(negedge clk);
        resp = want_resp && (pend.size() != 0);
        bus_if.IF_enable    = en;
        bus_if.IF_mem_addr  = addr;
        bus_if.IF_skip      = skip;
        bus_if.IF_accept    = acc;
        bus_if.inst_addr_ok = aok;
        bus_if.inst_data_ok = resp;
        bus_if.inst_rdata   = resp ? pend[0].data : $urandom();
        #1;
        exp_req = en && !skip && (pend.size() < MAXO) && ((pend.size() + fifo_m.size()) < DEPTH);
        checkOutput("inst_req", 32'(bus_if.inst_req), 32'(exp_req));
        checkOutput("IF_req_accept", 32'(bus_if.IF_req_accept), 32'(exp_req && aok));
        checkOutput("inst_addr", bus_if.inst_addr, addr);
        checkOutput("IF_ready", 32'(bus_if.IF_ready), 32'(fifo_m.size() != 0));
        if (fifo_m.size() != 0) begin
            checkOutput("IF_mem_rdata", bus_if.IF_mem_rdata, fifo_m[0]);
        end
`ifdef INTERLAYER_STATS_EN
        checkOutput("stat_drop_cnt", stat_drop_cnt, 32'(m_drop));
        checkOutput("stat_stall_cnt", stat_stall_cnt, 32'(m_stall));
`endif
        hs_seen      = bus_if.IF_req_accept;
        popped_valid = acc && !skip && bus_if.IF_ready;
        popped_word  = bus_if.IF_mem_rdata;

        pop_ok = acc && !skip && (fifo_m.size() != 0);
        if (pop_ok) void'(fifo_m.pop_front());
        if (resp) begin
            p = pend.pop_front();
            if (p.stale || skip) m_drop++;
            else fifo_m.push_back(p.data);
        end
        if (skip) begin
            fifo_m.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
        end
        if (en && !exp_req && !skip) m_stall++;
        if (exp_req && aok) begin
            p.data  = (word_src.size() != 0) ? word_src.pop_front() : $urandom();
            p.stale = 1'b0;
            pend.push_back(p);
        end
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_p               = 1'b1;
            bus_if.IF_enable    = 1'b1;
            bus_if.IF_mem_addr  = $urandom();
            bus_if.IF_skip      = 1'b0;
            bus_if.IF_accept    = 1'b0;
            bus_if.inst_addr_ok = 1'b1;
            bus_if.inst_data_ok = 1'b0;
            #1;
            checkOutput("rst_inst_req", 32'(bus_if.inst_req), 32'd0);
            checkOutput("rst_req_accept", 32'(bus_if.IF_req_accept), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_p = 1'b0;
        pend.delete();
        fifo_m.delete();
        word_src.delete();
        m_drop  = 0;
        m_stall = 0;
        checkOutput("rst_IF_ready", 32'(bus_if.IF_ready), 32'd0);
`ifdef INTERLAYER_STATS_EN
        checkOutput("rst_stat_drop", stat_drop_cnt, 32'd0);
        checkOutput("rst_stat_stall", stat_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        int hs_total;
        int npop;
        checks   = 0;
        failures = 0;
        m_drop   = 0;
        m_stall  = 0;
        rst_p               = 1'b1;
        bus_if.IF_enable    = 1'b0;
        bus_if.IF_mem_addr  = '0;
        bus_if.IF_skip      = 1'b0;
        bus_if.IF_accept    = 1'b0;
        bus_if.inst_rdata   = '0;
        bus_if.inst_addr_ok = 1'b0;
        bus_if.inst_data_ok = 1'b0;

        // Single fetch
        doReset(2);
        word_src.push_back(32'h24020001);
        applyStimulus(1, 32'hbfc00000, 0, 0, 1, 0);
        checkOutput("t1_handshake", 32'(hs_seen), 32'd1);
        applyStimulus(0, 32'hbfc00004, 0, 0, 0, 0);
        applyStimulus(0, 32'hbfc00004, 0, 0, 0, 1);
        applyStimulus(0, 32'hbfc00004, 0, 1, 0, 0);
        checkOutput("t1_ready", 32'(popped_valid), 32'd1);
        checkOutput("t1_data", popped_word, 32'h24020001);
        applyStimulus(1, 32'hbfc00004, 0, 0, 0, 0);

        // Backpressure: IF never accepts, bus always ready
        doReset(1);
        hs_total = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'h1000 + 32'(4 * i), 0, 0, 1, 1);
            hs_total += int'(hs_seen);
        end
        checkOutput("t2_handshakes", 32'(hs_total), 32'd4);
        checkOutput("t2_req_blocked", 32'(bus_if.inst_req), 32'd0);
        applyStimulus(1, 32'h2000, 0, 1, 1, 1);
        applyStimulus(1, 32'h2000, 0, 0, 0, 0);
        checkOutput("t2_req_after_pop", 32'(bus_if.inst_req), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 1, 0, 1);

        // Flush with two in flight and one queued
        doReset(1);
        word_src = '{32'h11110001, 32'h11110002, 32'h11110003, 32'h3c1a0000};
        applyStimulus(1, 32'hbfc00100, 0, 0, 1, 0);
        applyStimulus(1, 32'hbfc00104, 0, 0, 1, 0);
        applyStimulus(1, 32'hbfc00108, 0, 0, 1, 1);
        applyStimulus(1, 32'hbfc00108, 0, 0, 1, 0);
        applyStimulus(0, 32'hbfc0010c, 1, 1, 1, 0);
        applyStimulus(0, 32'hbfc0010c, 0, 0, 0, 0);
        checkOutput("t3_ready_after_skip", 32'(bus_if.IF_ready), 32'd0);
        applyStimulus(0, 32'hbfc0010c, 0, 0, 0, 1);
        applyStimulus(0, 32'hbfc0010c, 0, 0, 0, 1);
        applyStimulus(1, 32'hbfc00380, 0, 0, 1, 0);
        applyStimulus(0, 32'hbfc00384, 0, 0, 0, 1);
        applyStimulus(0, 32'hbfc00384, 0, 1, 0, 0);
        checkOutput("t3_delivered_valid", 32'(popped_valid), 32'd1);
        checkOutput("t3_delivered_word", popped_word, 32'h3c1a0000);
`ifdef INTERLAYER_STATS_EN
        checkOutput("t3_stat_drop", stat_drop_cnt, 32'd2);
`endif

        // Skip coincident with a response while two are in flight
        doReset(1);
        word_src = '{32'h22220001, 32'h22220002, 32'h22220003};
        applyStimulus(1, 32'h3000, 0, 0, 1, 0);
        applyStimulus(1, 32'h3004, 0, 0, 1, 0);
        applyStimulus(0, 32'h3008, 1, 0, 0, 1);
        applyStimulus(0, 32'h3008, 0, 0, 0, 1);
        applyStimulus(1, 32'h3008, 0, 0, 1, 0);
        checkOutput("t4_ready_zero", 32'(bus_if.IF_ready), 32'd0);
        applyStimulus(0, 32'h300c, 0, 0, 0, 1);
        applyStimulus(0, 32'h300c, 0, 1, 0, 0);
        checkOutput("t4_delivered_valid", 32'(popped_valid), 32'd1);
        checkOutput("t4_delivered_word", popped_word, 32'h22220003);

        // Streaming through a full queue: order kept across pointer wrap
        doReset(1);
        word_src = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        hs_total = 0;
        npop     = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(hs_total < 8, 32'h4000 + 32'(4 * i), 0, i >= 6, 1, 1);
            hs_total += int'(hs_seen);
            if (popped_valid && npop < 8) begin
                checkOutput("t5_order", popped_word, 32'(npop + 1));
                npop++;
            end
        end
        checkOutput("t5_popped", 32'(npop), 32'd8);

        // Credit-blocked stall cycles
        doReset(1);
        applyStimulus(1, 32'h5000, 0, 0, 1, 0);
        applyStimulus(1, 32'h5004, 0, 0, 1, 0);
        applyStimulus(0, 32'h5008, 0, 0, 0, 1);
        applyStimulus(0, 32'h5008, 0, 0, 0, 1);
        applyStimulus(1, 32'h5008, 0, 0, 1, 0);
        applyStimulus(1, 32'h500c, 0, 0, 1, 0);
        applyStimulus(0, 32'h5010, 0, 0, 0, 1);
        applyStimulus(0, 32'h5010, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h5010, 0, 0, 1, 0);
        applyStimulus(0, 32'h5010, 0, 0, 0, 0);
`ifdef INTERLAYER_STATS_EN
        checkOutput("t6_stat_stall", stat_stall_cnt, 32'd5);
`endif
        checkOutput("t6_queue_full", 32'(bus_if.IF_ready), 32'd1);
        doReset(1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset(1);
            end else begin
                applyStimulus($urandom_range(0, 99) < 80, $urandom(),
                              $urandom_range(0, 99) < 6, $urandom_range(0, 1) == 1,
                              $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55);
            end
        end

        $display("[TB] directed and random sequences complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
